// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: hazard FSM encoding, ID/EX control word, register constants.
package mips_pipe_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MD_WAIT = 2'd1;
  localparam logic [1:0] ST_MD_DONE = 2'd2;

  typedef enum logic [1:0] {
    RUN     = ST_RUN,
    MD_WAIT = ST_MD_WAIT,
    MD_DONE = ST_MD_DONE
  } hz_state_e;

  localparam int unsigned IDEX_CTRL_W = 20;
  localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_NOP = '0;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/muldiv_busy_cnt.sv
// Loadable down-counter tracking remaining mult/div busy cycles; saturates at zero.
module muldiv_busy_cnt #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, branch/jump flushes, mult/div structural stalls.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [REG_IDX_W-1:0] I_ID_RS,
  input  logic [REG_IDX_W-1:0] I_ID_RT,
  input  logic                 I_ID_UsesRT,
  input  logic                 I_ID_Jump,
  input  logic                 I_ID_MulDiv,
  input  logic                 I_ID_HiLoRead,
  input  logic                 I_EX_MemRead,
  input  logic [REG_IDX_W-1:0] I_EX_RT,
  input  logic                 I_EX_BranchTaken,
  output logic                 O_PC_Write,
  output logic                 O_IFID_Write,
  output logic                 O_IFID_Flush,
  output logic                 O_IDEX_Bubble,
  output logic                 O_MulDiv_Start,
  output logic                 O_MulDiv_Busy,
  output logic [31:0]          O_StallCycles
);

  hz_state_e state_q, state_d;

  logic load_use;
  logic md_hold;
  logic cnt_load, cnt_dec, cnt_zero;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_busy;

  muldiv_busy_cnt #(
    .CNT_W (CNT_W)
  ) u_busy_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (cnt_load),
    .load_val (CNT_W'(MULDIV_LAT - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign load_use = I_EX_MemRead && (I_EX_RT != REG_ZERO) &&
                    ((I_EX_RT == I_ID_RS) || (I_ID_UsesRT && (I_EX_RT == I_ID_RT)));

  // HI/LO consumers and new mult/div ops wait until the unit has written back.
  assign md_hold = (I_ID_MulDiv || I_ID_HiLoRead) && (state_q != RUN);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_start    = 1'b0;
    md_busy     = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      RUN:     ;
      MD_WAIT: begin
        md_busy = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = MD_DONE;
      end
      MD_DONE: state_d = RUN;
      default: state_d = RUN;
    endcase

    if (I_EX_BranchTaken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (md_hold || load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (I_ID_Jump) begin
      ifid_flush  = 1'b1;
    end else if (I_ID_MulDiv) begin
      // Only reachable in RUN: md_hold catches it in the other states.
      md_start = 1'b1;
      cnt_load = 1'b1;
      state_d  = MD_WAIT;
    end

    if (RESET) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      md_start    = 1'b0;
      md_busy     = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
    end
  end

  assign O_PC_Write     = pc_write;
  assign O_IFID_Write   = ifid_write;
  assign O_IFID_Flush   = ifid_flush;
  assign O_IDEX_Bubble  = idex_bubble;
  assign O_MulDiv_Start = md_start;
  assign O_MulDiv_Busy  = md_busy;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_q <= '0;
    end else if (!pc_write && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign O_StallCycles = stall_q;
`else
  assign O_StallCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl with MULDIV_LAT=4: directed scenarios plus randomized traffic vs a cycle-count model.
module tb_hazard_ctrl;

  localparam int unsigned LAT = 4;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, id_jump, id_muldiv, id_hilo, ex_memread, ex_br;
  logic pc_w, ifid_w, ifid_fl, idex_bub, md_start, md_busy;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  int          m_left;
  bit          m_done;
  int unsigned m_stalls;
  logic        e_pc, e_ifid, e_fl, e_bub, e_start, e_busy;
  logic [31:0] e_stalls;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(6)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .I_ID_RS          (id_rs),
    .I_ID_RT          (id_rt),
    .I_ID_UsesRT      (id_uses_rt),
    .I_ID_Jump        (id_jump),
    .I_ID_MulDiv      (id_muldiv),
    .I_ID_HiLoRead    (id_hilo),
    .I_EX_MemRead     (ex_memread),
    .I_EX_RT          (ex_rt),
    .I_EX_BranchTaken (ex_br),
    .O_PC_Write       (pc_w),
    .O_IFID_Write     (ifid_w),
    .O_IFID_Flush     (ifid_fl),
    .O_IDEX_Bubble    (idex_bub),
    .O_MulDiv_Start   (md_start),
    .O_MulDiv_Busy    (md_busy),
    .O_StallCycles    (stall_cnt)
  );

  // Reference: the unit is busy for LAT cycles after a start, then one writeback cycle.
  task automatic model_eval();
    bit lu, hold;
    lu = ex_memread && (ex_rt != 5'd0) && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    hold = (m_left > 0 || m_done) && (id_muldiv || id_hilo);
    e_busy = (m_left > 0); e_start = 0; e_fl = 0; e_bub = 0; e_pc = 1; e_ifid = 1;
    e_stalls = PERF ? 32'(m_stalls) : 32'd0;
    if (ex_br) begin e_fl = 1; e_bub = 1; end
    else if (hold || lu) begin e_pc = 0; e_ifid = 0; e_bub = 1; end
    else if (id_jump) e_fl = 1;
    else if (id_muldiv) e_start = 1;
  endtask

  task automatic model_tick();
    if (!e_pc) m_stalls++;
    if (m_left > 0) begin m_left--; if (m_left == 0) m_done = 1; end
    else if (m_done) m_done = 0;
    else if (e_start) m_left = LAT;
  endtask

  task automatic set_nop();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0; id_muldiv = 0; id_hilo = 0;
    ex_memread = 0; ex_rt = 0; ex_br = 0;
  endtask

  task automatic do_reset();
    set_nop();
    RESET = 1'b1;
    #1;
    @(negedge CLK);
    RESET = 1'b0;
    m_left = 0; m_done = 0; m_stalls = 0;
  endtask

  task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic jump, input logic muldiv, input logic hilo,
                       input logic memread, input logic [4:0] exrt, input logic br);
    @(negedge CLK);
    id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_jump = jump; id_muldiv = muldiv;
    id_hilo = hilo; ex_memread = memread; ex_rt = exrt; ex_br = br;
    #1;
    model_eval();
    model_tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    set_nop(); id_muldiv = 1; id_jump = 1;
    #1;
    checks++; if (pc_w !== 1'b0) begin errors++; $display("FAIL reset_pc got %b exp 0", pc_w); end
    checks++; if (ifid_w !== 1'b0) begin errors++; $display("FAIL reset_ifid_w got %b exp 0", ifid_w); end
    checks++; if (ifid_fl !== 1'b1) begin errors++; $display("FAIL reset_flush got %b exp 1", ifid_fl); end
    checks++; if (idex_bub !== 1'b1) begin errors++; $display("FAIL reset_bubble got %b exp 1", idex_bub); end
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", md_start); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", md_busy); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stalls got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    apply(5, 0, 0, 0, 0, 0, 1, 5, 0);
    checks++; if (pc_w !== 1'b0) begin errors++; $display("FAIL lu_pc got %b exp 0", pc_w); end
    checks++; if (ifid_w !== 1'b0) begin errors++; $display("FAIL lu_ifid_w got %b exp 0", ifid_w); end
    checks++; if (idex_bub !== 1'b1) begin errors++; $display("FAIL lu_bubble got %b exp 1", idex_bub); end
    checks++; if (ifid_fl !== 1'b0) begin errors++; $display("FAIL lu_flush got %b exp 0", ifid_fl); end
    apply(5, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({pc_w, ifid_w, idex_bub} !== 3'b110) begin errors++; $display("FAIL lu_after got %b exp 110", {pc_w, ifid_w, idex_bub}); end
    apply(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checks++; if ({pc_w, idex_bub} !== 2'b10) begin errors++; $display("FAIL lu_r0 got %b exp 10", {pc_w, idex_bub}); end
    apply(3, 7, 1, 0, 0, 0, 1, 7, 0);
    checks++; if ({pc_w, idex_bub} !== 2'b01) begin errors++; $display("FAIL lu_rt got %b exp 01", {pc_w, idex_bub}); end
    apply(3, 7, 0, 0, 0, 0, 1, 7, 0);
    checks++; if ({pc_w, idex_bub} !== 2'b10) begin errors++; $display("FAIL lu_rt_unused got %b exp 10", {pc_w, idex_bub}); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    apply(5, 0, 0, 1, 1, 0, 1, 5, 1);
    checks++; if ({ifid_fl, idex_bub, pc_w, md_start} !== 4'b1110) begin errors++; $display("FAIL br_prio got %b exp 1110", {ifid_fl, idex_bub, pc_w, md_start}); end
    apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if ({md_busy, pc_w} !== 2'b01) begin errors++; $display("FAIL br_stays_run got %b exp 01", {md_busy, pc_w}); end
  endtask

  task automatic test_muldiv_latency();
    int busy_n = 0;
    bit start_again = 0;
    do_reset();
    apply(1, 2, 1, 0, 1, 0, 0, 0, 0);
    checks++; if ({md_start, md_busy, pc_w, idex_bub} !== 4'b1010) begin errors++; $display("FAIL md_start got %b exp 1010", {md_start, md_busy, pc_w, idex_bub}); end
    for (int i = 0; i < LAT; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (md_busy === 1'b1) busy_n++;
      if (md_start !== 1'b0) start_again = 1;
    end
    checks++; if (busy_n != LAT) begin errors++; $display("FAIL md_busy_len got %0d exp %0d", busy_n, LAT); end
    checks++; if (start_again) begin errors++; $display("FAIL md_start_once got repeat exp single pulse"); end
    apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if ({md_busy, pc_w, idex_bub} !== 3'b001) begin errors++; $display("FAIL md_done got %b exp 001", {md_busy, pc_w, idex_bub}); end
    apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if ({md_busy, pc_w} !== 2'b01) begin errors++; $display("FAIL md_back_run got %b exp 01", {md_busy, pc_w}); end
  endtask

  task automatic test_mfhi_stall();
    int stalled = 0;
    bit issued = 0;
    do_reset();
    apply(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && !issued; i++) begin
      apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
      if (pc_w === 1'b1) issued = 1; else stalled++;
    end
    checks++; if (!issued || stalled != LAT + 1) begin errors++; $display("FAIL mfhi_stall got %0d issued %0d exp %0d", stalled, issued, LAT + 1); end
    do_reset();
    apply(0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply(1, 2, 1, 0, 0, 0, 0, 0, 0);
    checks++; if ({md_busy, pc_w, idex_bub} !== 3'b110) begin errors++; $display("FAIL add_during_md got %b exp 110", {md_busy, pc_w, idex_bub}); end
  endtask

  task automatic test_async_reset();
    do_reset();
    apply(0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL ares_pre got %b exp 1", md_busy); end
    RESET = 1'b1;
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL ares_busy got %b exp 0", md_busy); end
    @(negedge CLK);
    RESET = 1'b0;
    m_left = 0; m_done = 0; m_stalls = 0;
    #1;
    checks++; if ({pc_w, md_busy} !== 2'b10) begin errors++; $display("FAIL ares_release got %b exp 10", {pc_w, md_busy}); end
    apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (pc_w !== 1'b1) begin errors++; $display("FAIL ares_run got %b exp 1", pc_w); end
  endtask

  task automatic test_perf_count();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(9, 0, 0, 0, 0, 0, 1, 9, 0);
      apply(9, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    apply(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
    exp = PERF ? 32'd8 : 32'd0;
    checks++; if (stall_cnt !== exp) begin errors++; $display("FAIL perf_cnt got %0d exp %0d", stall_cnt, exp); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0));
      checks++;
      if ({pc_w, ifid_fl, idex_bub, md_start, md_busy} !== {e_pc, e_fl, e_bub, e_start, e_busy}) begin
        errors++;
        $display("FAIL rand_ctl cyc %0d got pc%b fl%b bub%b st%b bsy%b exp pc%b fl%b bub%b st%b bsy%b",
                 n, pc_w, ifid_fl, idex_bub, md_start, md_busy, e_pc, e_fl, e_bub, e_start, e_busy);
      end
      if (!e_fl) begin
        checks++;
        if (ifid_w !== e_ifid) begin errors++; $display("FAIL rand_ifid cyc %0d got %b exp %b", n, ifid_w, e_ifid); end
      end
      checks++;
      if (stall_cnt !== e_stalls) begin errors++; $display("FAIL rand_stalls cyc %0d got %0d exp %0d", n, stall_cnt, e_stalls); end
    end
  endtask

  initial begin
    set_nop();
    m_left = 0; m_done = 0; m_stalls = 0;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_muldiv_latency();
    test_mfhi_stall();
    test_async_reset();
    test_perf_count();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; the sequencing authority for the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards, resolves taken branches and jumps with flushes, and stalls front-end issue while the multi-cycle multiply/divide unit is busy.
- Sits in the ID stage; its outputs drive PC write enable, IF/ID write/flush, and ID/EX bubble insertion (ID/EX control word forced to 0).

Parameters:
- MULDIV_LAT, 32, cycles the mult/div unit needs after start (legal 2..63).
- CNT_W, 6, width of the mult/div down-counter; must hold MULDIV_LAT.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- I_ID_RS  in  5  rs field of instruction in ID.
- I_ID_RT  in  5  rt field of instruction in ID.
- I_ID_UsesRT  in  1  ID instruction reads rt as a source.
- I_ID_Jump  in  1  ID instruction is J/JAL/JR.
- I_ID_MulDiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- I_ID_HiLoRead  in  1  ID instruction is MFHI/MFLO.
- I_EX_MemRead  in  1  instruction in EX is a load.
- I_EX_RT  in  5  destination rt of instruction in EX.
- I_EX_BranchTaken  in  1  branch in EX resolved taken.
- O_PC_Write  out  1  PC update enable.
- O_IFID_Write  out  1  IF/ID load enable.
- O_IFID_Flush  out  1  IF/ID cleared to NOP at next edge.
- O_IDEX_Bubble  out  1  ID/EX captures an all-zero control word.
- O_MulDiv_Start  out  1  one-cycle start pulse to the mult/div unit.
- O_MulDiv_Busy  out  1  high in MD_WAIT.
- O_StallCycles  out  32  performance counter (see Optional Feature).

Behaviour:
- States: RUN, MD_WAIT, MD_DONE. State and counter are registered; outputs are combinational from state and inputs.
- Reset values (asynchronous):
  - State = RUN, counter = 0.
  - With RESET high, outputs force to O_PC_Write=0, O_IFID_Write=0, O_IFID_Flush=1, O_IDEX_Bubble=1, O_MulDiv_Start=0, O_MulDiv_Busy=0, O_StallCycles=0.
- Load-use hazard: LU = I_EX_MemRead and I_EX_RT!=0 and (I_EX_RT==I_ID_RS or (I_ID_UsesRT and I_EX_RT==I_ID_RT)).
- Priority within RUN, highest first:
  - (1) I_EX_BranchTaken: PC_Write=1, IFID_Flush=1, IDEX_Bubble=1. Overrides LU, Jump and MulDiv in the same cycle; a squashed MulDiv does not start.
  - (2) LU: PC_Write=0, IFID_Write=0, IDEX_Bubble=1. Exactly one bubble per hazard; the next cycle re-evaluates and normally proceeds.
  - (3) I_ID_Jump: PC_Write=1, IFID_Flush=1, IDEX_Bubble=0 (the jump itself proceeds).
  - (4) I_ID_MulDiv: O_MulDiv_Start=1 for one cycle, the instruction proceeds to EX, counter loads MULDIV_LAT-1, next state MD_WAIT.
  - Otherwise PC_Write=1, IFID_Write=1, no flush or bubble.
- MD_WAIT:
  - O_MulDiv_Busy=1; counter decrements each cycle.
  - If the ID instruction is MulDiv or HiLoRead: PC_Write=0, IFID_Write=0, IDEX_Bubble=1 (structural stall).
  - Other instructions proceed under RUN rules (1)-(3).
  - I_EX_BranchTaken still flushes, and the busy count continues unaffected.
  - Counter==0 moves to MD_DONE.
- MD_DONE: one cycle in which Busy=0 and a stalled HiLoRead or MulDiv is still held (HI/LO writeback slot). Returns to RUN.
- Counter arithmetic is unsigned CNT_W bits and never wraps below 0.
- RESET mid-operation aborts MD_WAIT immediately and returns to RUN. The mult/div unit is reset by the same signal.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: O_StallCycles is a 32-bit register, cleared by RESET, incremented on every cycle with O_PC_Write=0 and RESET low. Saturates at 0xFFFFFFFF.
- Undefined: O_StallCycles is tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - State encoding localparams (RUN=2'd0, MD_WAIT=2'd1, MD_DONE=2'd2).
  - ID/EX control-word width (20) and the NOP/bubble control value (0).
  - Register index 0 constant.
- One natural sub-module: muldiv_busy_cnt, a loadable down-counter with a zero flag.

Test Plan:
- Load r5 in EX (I_EX_MemRead=1, I_EX_RT=5) with ADD in ID (I_ID_RS=5) -> one cycle with PC_Write=0, IFID_Write=0, IDEX_Bubble=1, then normal flow. Repeat with I_EX_RT=0 -> no stall.
- I_EX_BranchTaken=1 together with LU and I_ID_MulDiv=1 -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1, MulDiv_Start=0, state stays RUN.
- MULDIV_LAT=4: MulDiv in ID -> Start pulses one cycle, Busy high for exactly 4 cycles, then one MD_DONE cycle.
- MULDIV_LAT=4: MFHI in ID on the cycle after start -> stalled 5 cycles (4 MD_WAIT + 1 MD_DONE), issues on the 6th; an ADD instead issues with no stall.
- Assert RESET asynchronously mid-MD_WAIT (counter=2) -> Busy drops without a clock edge; after release, state is RUN and PC_Write=1.
- HAZ_PERF_CNT_EN defined: 3 load-use stalls plus a 5-cycle MFHI stall -> O_StallCycles=8. Undefined -> O_StallCycles stays 0.
